spw_light_rxfifo_pio: RTL

//  Avalon-MM slave that buffers SpaceWire receive characters for the Nios host. Replaces the

---
 rtl/spw_light_pkg.sv | 26 ++
 rtl/spw_light_sync_fifo.sv | 59 +++++
 rtl/spw_light_rxfifo_pio.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spw_light_pkg.sv
// Shared constants for the spw_light receive path: Avalon register offsets,
// bit positions inside the DATA/STATUS words and the interrupt cause indices.
package spw_light_pkg;

  // Avalon word offsets of the receive FIFO register block
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_THRESH   = 2'd3;

  // Bit positions inside the DATA and STATUS read words
  localparam int DATA_VALID_BIT   = 31;
  localparam int STATUS_OVF_BIT   = 31;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_EMPTY_BIT = 16;

  // Interrupt cause indices; shared by IRQ_MASK bits and the cause vector
  localparam int IRQ_NOTEMPTY = 0;
  localparam int IRQ_LEVEL    = 1;
  localparam int IRQ_OVF      = 2;
  localparam int IRQ_W        = 3;

  // Software write that clears the sticky overflow flag
  localparam int STATUS_OVF_CLR_BIT = 31;

endpackage

// File: rtl/spw_light_sync_fifo.sv
// Register-array synchronous FIFO. push is ignored while full and pop is
// ignored while empty, so callers may present raw requests. level runs
// 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH (a power of two).
module spw_light_sync_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Full/empty come straight from the registered level, so they are glitch-free
  assign full    = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: written on every accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and fill-level bookkeeping; push+pop together leaves level alone
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spw_light_rxfifo_pio.sv
// Avalon-MM slave buffering SpaceWire receive characters for the host.
// Holds the register decode, sticky overflow, irq mask/threshold and the
// registered interrupt; character storage lives in spw_light_sync_fifo.
//
// Receive handshake: a character transfers on a clk edge where in_valid and
// in_ready are both high. in_ready is !full from the registered fill level and
// does not depend on in_valid. in_valid while full drops that character and
// sets the sticky overflow flag, even if the host pops in the same cycle.
module spw_light_rxfifo_pio
  import spw_light_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic [LEVEL_W-1:0]    level;
  logic                  overflow;
  logic [IRQ_W-1:0]      irq_mask;
  logic [IRQ_W-1:0]      irq_cause;
  logic [LEVEL_W-1:0]    thresh;
  logic [31:0]           rd_mux;
  logic                  rd_stb;
  logic                  wr_stb;
  logic                  pop;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic                  unused_wdata;

  assign rd_stb   = chipselect & read;
  assign wr_stb   = chipselect & write;
  assign pop      = rd_stb & (address == REG_DATA);
  assign in_ready = ~full;
  assign ovf_set  = in_valid & full;
  assign ovf_clr  = wr_stb & (address == REG_STATUS) & writedata[STATUS_OVF_CLR_BIT];
  // Only a few writedata bits reach a register; fold the rest away
  assign unused_wdata = ^writedata;

  spw_light_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Interrupt causes from current (pre-edge) state
  always_comb begin
    irq_cause               = '0;
    irq_cause[IRQ_NOTEMPTY] = ~empty;
    irq_cause[IRQ_LEVEL]    = (level >= thresh);
    irq_cause[IRQ_OVF]      = overflow;
  end

  // Read word selection; STATUS reflects the state before this edge
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA: begin
        if (!empty) begin
          rd_mux[DATA_WIDTH-1:0]  = head;
          rd_mux[DATA_VALID_BIT]  = 1'b1;
        end
      end
      REG_STATUS: begin
        rd_mux[LEVEL_W-1:0]      = level;
        rd_mux[STATUS_EMPTY_BIT] = empty;
        rd_mux[STATUS_FULL_BIT]  = full;
        rd_mux[STATUS_OVF_BIT]   = overflow;
      end
      REG_IRQ_MASK: rd_mux[IRQ_W-1:0]   = irq_mask;
      REG_THRESH:   rd_mux[LEVEL_W-1:0] = thresh;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data: updated only on a read strobe, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_stb) begin
      readdata <= rd_mux;
    end
  end

  // Host-writable control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      thresh   <= LEVEL_W'(FIFO_DEPTH / 2);
    end else if (wr_stb) begin
      if (address == REG_IRQ_MASK) irq_mask <= writedata[IRQ_W-1:0];
      if (address == REG_THRESH)   thresh   <= writedata[LEVEL_W-1:0];
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  // Level interrupt, one cycle behind its causes
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_mask & irq_cause);
    end
  end

endmodule
